// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one clocked
// write port, optional write-to-read bypass, and a per-register pending-write
// scoreboard used by decode to stall on RAW hazards.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZR    = (ZERO_REG != 0);
  localparam bit          BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic wr_ok;
  logic rsv_ok;
  logic cnt_inc;
  logic cnt_dec;
  logic err_next;

  // Qualify requests (address 0 is inert under ZERO_REG) and derive counter/error updates
  always_comb begin
    wr_ok    = wr_en  & ~(ZR & (wr_addr  == '0));
    rsv_ok   = rsv_en & ~(ZR & (rsv_addr == '0));
    // a reserve that lands on a clear bit adds one pending register
    cnt_inc  = rsv_ok & ~pend[rsv_addr];
    // a write clears a set bit unless the same-edge reserve keeps it owned
    cnt_dec  = wr_ok & pend[wr_addr] & ~(rsv_ok & (rsv_addr == wr_addr));
    // WAW: reserving a register that is still pending and not retiring this edge
    err_next = rsv_ok & pend[rsv_addr] & ~(wr_ok & (wr_addr == rsv_addr));
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Pending scoreboard; reserve is applied last so the new producer wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (wr_ok) begin
        pend[wr_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        pend[rsv_addr] <= 1'b1;
      end
    end
  end

  // Pending counter and WAW error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      pend_cnt <= pend_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      rsv_err  <= err_next;
    end
  end

  // Read port 1 with optional bypass of the in-flight write
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_busy1 = pend[rd_addr1];
    if (BP && wr_ok && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      rd_busy1 = 1'b0;
    end
    if (ZR && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
  end

  // Read port 2 with optional bypass of the in-flight write
  always_comb begin
    rd_data2 = regs[rd_addr2];
    rd_busy2 = pend[rd_addr2];
    if (BP && wr_ok && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      rd_busy2 = 1'b0;
    end
    if (ZR && (rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share all
// inputs and are compared every cycle against a behavioural model, plus
// directed literal checks for the documented scenarios.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [31:0] wr_data;

  logic [31:0] d1_b, d2_b, d1_n, d2_n;
  logic        b1_b, b2_b, b1_n, b2_n;
  logic        err_b, err_n;
  logic [5:0]  cnt_b, cnt_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_b), .rd_data2(d2_b),
    .rd_busy1(b1_b), .rd_busy2(b2_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(err_b), .pend_cnt(cnt_b)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_n), .rd_data2(d2_n),
    .rd_busy1(b1_n), .rd_busy2(b2_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(err_n), .pend_cnt(cnt_n)
  );

  // Behavioural model: architectural register values, pending set, last error
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= '0;
        m_pend[i] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_regs[wr_addr] <= wr_data;
        m_pend[wr_addr] <= 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] <= 1'b1;
      m_err <= rsv_en && rsv_addr != 5'd0 && m_pend[rsv_addr] &&
               !(wr_en && wr_addr == rsv_addr);
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("b.rd_data1", 64'(d1_b), 64'(exp_data(rd_addr1, 1'b1)));
      chk("b.rd_data2", 64'(d2_b), 64'(exp_data(rd_addr2, 1'b1)));
      chk("b.rd_busy1", 64'(b1_b), 64'(exp_busy(rd_addr1, 1'b1)));
      chk("b.rd_busy2", 64'(b2_b), 64'(exp_busy(rd_addr2, 1'b1)));
      chk("n.rd_data1", 64'(d1_n), 64'(exp_data(rd_addr1, 1'b0)));
      chk("n.rd_data2", 64'(d2_n), 64'(exp_data(rd_addr2, 1'b0)));
      chk("n.rd_busy1", 64'(b1_n), 64'(exp_busy(rd_addr1, 1'b0)));
      chk("n.rd_busy2", 64'(b2_n), 64'(exp_busy(rd_addr2, 1'b0)));
      chk("b.rsv_err", 64'(err_b), 64'(m_err));
      chk("n.rsv_err", 64'(err_n), 64'(m_err));
      chk("b.pend_cnt", 64'(cnt_b), 64'(exp_cnt()));
      chk("n.pend_cnt", 64'(cnt_n), 64'(exp_cnt()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  initial begin
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; rsv_addr = '0;
    wr_en = 1'b0; rsv_en = 1'b0; wr_data = '0;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    // Reset state across all addresses
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      #1;
      chk("rst.data1", 64'(d1_b), 64'd0);
      chk("rst.busy2", 64'(b2_b), 64'd0);
    end
    chk("rst.cnt", 64'(cnt_b), 64'd0);
    chk("rst.err", 64'(err_b), 64'd0);

    // Write r5 with bypass observed the same cycle
    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    #1;
    chk("byp.same", 64'(d1_b), 64'hDEADBEEF);
    chk("nobyp.same", 64'(d1_n), 64'd0);
    step(); idle();
    chk("nobyp.next", 64'(d1_n), 64'hDEADBEEF);

    // Reserve r7, then retire it with a write
    rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr2 = 5'd7;
    #1;
    chk("rsv.same_busy", 64'(b2_b), 64'd0);
    step(); idle();
    chk("rsv.busy", 64'(b2_b), 64'd1);
    chk("rsv.cnt", 64'(cnt_b), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    #1;
    chk("wr7.byp_busy", 64'(b2_b), 64'd0);
    chk("wr7.nobyp_busy", 64'(b2_n), 64'd1);
    chk("wr7.byp_data", 64'(d2_b), 64'h1234);
    step(); idle();
    chk("wr7.cnt", 64'(cnt_b), 64'd0);
    chk("wr7.busy_n", 64'(b2_n), 64'd0);
    chk("wr7.data_n", 64'(d2_n), 64'h1234);

    // Double reserve r9 -> one-cycle WAW pulse
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    chk("waw.first", 64'(err_b), 64'd0);
    step(); idle();
    chk("waw.err", 64'(err_b), 64'd1);
    chk("waw.err_n", 64'(err_n), 64'd1);
    chk("waw.cnt", 64'(cnt_b), 64'd1);
    step();
    chk("waw.pulse", 64'(err_b), 64'd0);

    // Same-edge write + reserve of r9
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd9;
    step(); idle();
    rd_addr1 = 5'd9;
    #1;
    chk("wrrsv.err", 64'(err_b), 64'd0);
    chk("wrrsv.cnt", 64'(cnt_b), 64'd1);
    chk("wrrsv.busy", 64'(b1_b), 64'd1);
    chk("wrrsv.data", 64'(d1_b), 64'h99);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
    step(); idle();

    // Register 0 ignores writes and reserves
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    chk("r0.byp_data", 64'(d1_b), 64'd0);
    step(); idle();
    chk("r0.data", 64'(d2_b), 64'd0);
    chk("r0.busy", 64'(b1_b), 64'd0);
    chk("r0.cnt", 64'(cnt_b), 64'd0);
    chk("r0.err", 64'(err_b), 64'd0);

    // Randomized traffic concentrated on a few registers to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      step();
      wr_en    = 1'($urandom_range(0, 1));
      rsv_en   = ($urandom_range(0, 2) == 0);
      wr_addr  = pick();
      rsv_addr = pick();
      rd_addr1 = pick();
      rd_addr2 = ($urandom_range(0, 4) == 0) ? wr_addr : pick();
      wr_data  = $urandom;
    end
    step(); idle();

    // Clean slate, reserve r1..r4, then asynchronous reset mid-cycle
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      rsv_en = 1'b1; rsv_addr = 5'(i);
    end
    step(); idle();
    chk("pre.cnt", 64'(cnt_b), 64'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.cnt", 64'(cnt_b), 64'd0);
    chk("arst.cnt_n", 64'(cnt_n), 64'd0);
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(i);
      #1;
      chk("arst.busy", 64'(b1_b), 64'd0);
      chk("arst.data", 64'(d2_n), 64'd0);
    end
    rst_n = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
